// File: rtl/fib_reverse_walker_if.sv
// Handshake bundle for the reverse Fibonacci walker: load request and pair in,
// emitted term stream and walk status out.
interface fib_reverse_walker_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] f_hi;
    logic [WIDTH-1:0] f_lo;
    logic             out_ready;
    logic [WIDTH-1:0] term;
    logic             term_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] term_cnt;

    modport master (
        output start, f_hi, f_lo, out_ready,
        input  term, term_valid, busy, done, error, term_cnt
    );

    modport slave (
        input  start, f_hi, f_lo, out_ready,
        output term, term_valid, busy, done, error, term_cnt
    );
endinterface

// File: rtl/fib_reverse_walker.sv
// Walks a Fibonacci sequence backwards from a loaded pair (F(n), F(n-1)) down to 0,
// one term per accepted handshake, flagging pairs that cannot be Fibonacci neighbours.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fib_reverse_walker #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fib_reverse_walker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // hi - lo computed as hi + ~lo + 1; a clear carry-out means lo > hi (borrow).
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        full_adder u_fa (
            .a   (hi_q[i]),
            .b   (~lo_q[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    assign borrow = ~carry[WIDTH];

    always_comb begin
        // NOTE: every target takes its held value first, so no branch of the case infers a latch.
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    hi_d    = bus.f_hi;
                    lo_d    = bus.f_lo;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.out_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (hi_q == '0) begin
                        state_d = DONE;
                    end else if (borrow) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        hi_d = lo_q;
                        lo_d = diff;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // hi is never disturbed on the final step, so it doubles as the "last emitted term".
    assign bus.term       = hi_q;
    assign bus.term_valid = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.error      = err_q;
    assign bus.term_cnt   = cnt_q;
endmodule
